// File: rtl/io_pkg.sv
// Shared constants and helpers for the board I/O conditioning blocks
// (debouncers, synchronisers, LED pulse stretchers).
package io_pkg;

  // 0.1 s at a 50 MHz board clock.
  localparam int HOLD_CYCLES_DEFAULT = 5000000;

  localparam int HOLD_CYCLES_MAX = 1 << 24;

  // Width of a down-counter that must hold values 0..hold-1; never below 1 bit.
  function automatic int cnt_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/stretch_bit.sv
// One pulse-stretcher channel: any high input sample holds the output high
// for HOLD_CYCLES cycles, retriggerable.
module stretch_bit
  import io_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_out;

  // r_cnt counts the remaining high cycles after the current one; it only
  // decrements while non-zero so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (in) begin
      r_cnt <= LOAD_VAL;
      r_out <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_out <= 1'b1;
    end else begin
      r_out <= 1'b0;
    end
  end

  assign out = r_out;

endmodule

// File: rtl/pulse_stretcher.sv
// WIDTH independent LED pulse stretchers plus a registered "any channel busy"
// flag aligned with the channel outputs.
module pulse_stretcher
  import io_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             busy_any
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [WIDTH-1:0] w_out;
  logic             w_any_in;
  logic [CW-1:0]    r_busy_cnt;
  logic             r_busy_any;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      stretch_bit #(
        .HOLD_CYCLES(HOLD_CYCLES)
      ) u_stretch_bit (
        .clk  (clk),
        .reset(reset),
        .in   (in[gi]),
        .out  (w_out[gi])
      );
    end
  endgenerate

  assign w_any_in = |in;

  // Every channel reloads the same value, so the longest remaining hold is
  // tracked by one counter fed from the OR of the inputs. Its flag equals the
  // OR of the channel outputs registered at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_cnt <= '0;
      r_busy_any <= 1'b0;
    end else if (w_any_in) begin
      r_busy_cnt <= LOAD_VAL;
      r_busy_any <= 1'b1;
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - CW'(1);
      r_busy_any <= 1'b1;
    end else begin
      r_busy_any <= 1'b0;
    end
  end

  assign out      = w_out;
  assign busy_any = r_busy_any;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: HOLD_CYCLES=5 and HOLD_CYCLES=1 instances on the
// same stimulus, a last-event-time model, and hand-computed directed checks.
module tb_pulse_stretcher;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         tb_rst = 1'b1;
  logic [W-1:0] tb_in = '0;
  logic [W-1:0] out5, out1;
  logic         busy5, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.WIDTH(W), .HOLD_CYCLES(5)) dut5 (
    .clk(clk), .reset(tb_rst), .in(tb_in), .out(out5), .busy_any(busy5)
  );

  pulse_stretcher #(.WIDTH(W), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(tb_rst), .in(tb_in), .out(out1), .busy_any(busy1)
  );

  // Model: out[i] after edge t is high iff the most recent in[i]=1 edge e
  // (not cancelled by a later reset edge) satisfies t - e < HOLD.
  initial begin : model_cmp
    int cyc;
    int last_hit [W];
    bit valid [W];
    logic [W-1:0] exp5, exp1;
    cyc = 0;
    for (int i = 0; i < W; i++) begin
      last_hit[i] = 0;
      valid[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < W; i++) begin
        if (tb_rst) valid[i] = 0;
        else if (tb_in[i]) begin
          valid[i] = 1;
          last_hit[i] = cyc;
        end
        exp5[i] = valid[i] && (cyc - last_hit[i] < 5);
        exp1[i] = valid[i] && (cyc - last_hit[i] < 1);
      end
      #1;
      n_cmp++;
      if (out5 !== exp5 || busy5 !== (|exp5)) begin
        n_bad++;
        $display("FAIL model_h5 cyc=%0d out=%b busy=%b expected out=%b busy=%b",
                 cyc, out5, busy5, exp5, |exp5);
      end
      n_cmp++;
      if (out1 !== exp1 || busy1 !== (|exp1)) begin
        n_bad++;
        $display("FAIL model_h1 cyc=%0d out=%b busy=%b expected out=%b busy=%b",
                 cyc, out1, busy1, exp1, |exp1);
      end
    end
  end

  task automatic tick(input logic [W-1:0] v, input logic r);
    @(negedge clk);
    tb_in  = v;
    tb_rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] eo, input logic eb);
    n_cmp++;
    if (out5 !== eo || busy5 !== eb) begin
      n_bad++;
      $display("FAIL %s out=%b busy=%b expected out=%b busy=%b",
               name, out5, busy5, eo, eb);
    end
  endtask

  initial begin : stim
    logic [W-1:0] v;
    // reset: everything clear regardless of in
    tick(4'b1111, 1'b1);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    chk("reset", 4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    chk("idle", 4'b0000, 1'b0);

    // single pulse: 5 cycles high
    tick(4'b0001, 1'b0);
    chk("single_first", 4'b0001, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tick(4'b0000, 1'b0);
      chk("single_hold", 4'b0001, 1'b1);
    end
    tick(4'b0000, 1'b0);
    chk("single_end", 4'b0000, 1'b0);

    // retrigger at k and k+3: 8 cycles high with no gap
    for (int j = 0; j < 8; j++) begin
      tick((j == 0 || j == 3) ? 4'b0010 : 4'b0000, 1'b0);
      chk("retrig_hold", 4'b0010, 1'b1);
    end
    tick(4'b0000, 1'b0);
    chk("retrig_end", 4'b0000, 1'b0);

    // level input for 10 cycles: 14 cycles high
    for (int j = 0; j < 14; j++) begin
      tick((j < 10) ? 4'b0100 : 4'b0000, 1'b0);
      chk("level_hold", 4'b0100, 1'b1);
    end
    tick(4'b0000, 1'b0);
    chk("level_end", 4'b0000, 1'b0);

    // reset mid-hold aborts with no residue
    tick(4'b1000, 1'b0);
    chk("rst_mid_start", 4'b1000, 1'b1);
    tick(4'b0000, 1'b0);
    chk("rst_mid_hold", 4'b1000, 1'b1);
    tick(4'b0000, 1'b1);
    chk("rst_mid_abort", 4'b0000, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick(4'b0000, 1'b0);
      chk("rst_mid_after", 4'b0000, 1'b0);
    end
    // input honoured on first edge after reset drops
    tick(4'b0000, 1'b1);
    tick(4'b0100, 1'b0);
    chk("post_reset_honour", 4'b0100, 1'b1);
    for (int j = 0; j < 5; j++) tick(4'b0000, 1'b0);
    chk("post_reset_clear", 4'b0000, 1'b0);

    // simultaneous channels
    tick(4'b1010, 1'b0); chk("simul_k",   4'b1010, 1'b1);
    tick(4'b0000, 1'b0); chk("simul_k1",  4'b1010, 1'b1);
    tick(4'b0001, 1'b0); chk("simul_k2",  4'b1011, 1'b1);
    tick(4'b0000, 1'b0); chk("simul_k3",  4'b1011, 1'b1);
    tick(4'b0000, 1'b0); chk("simul_k4",  4'b1011, 1'b1);
    tick(4'b0000, 1'b0); chk("simul_k5",  4'b0001, 1'b1);
    tick(4'b0000, 1'b0); chk("simul_k6",  4'b0001, 1'b1);
    tick(4'b0000, 1'b0); chk("simul_k7",  4'b0000, 1'b0);

    // random traffic with sparse events and occasional reset
    for (int j = 0; j < 600; j++) begin
      for (int i = 0; i < W; i++) v[i] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 15);
      tick(v, ($urandom_range(0, 59) == 0));
    end
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
